// File: rtl/qam_pkg.sv
// Shared QAM receive-chain types and helpers (symbol length, state enum, Gray decode).
// Gray decode is applied by the serializer only when P2S_GRAY_EN is defined.
package qam_pkg;

   typedef enum logic {IDLE, RUN} p2s_state_t;

   function automatic int sym_len(input int bpr);
      return 2 * bpr;
   endfunction

   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Zero-extended rails decode correctly: leading zero Gray bits stay zero.
   function automatic logic [7:0] gray2bin(input logic [7:0] g);
      logic [7:0] b;
      b[7] = g[7];
      for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
      return b;
   endfunction

endpackage

// File: rtl/qam_p2s_serializer_word_build.sv
// Combinational word builder: rail order, bit order, optional Gray decode.
// Gray decode enabled with `define P2S_GRAY_EN.
module p2s_word_build
   import qam_pkg::*;
#(
   parameter int BITS_PER_RAIL = 2,
   parameter int Q_FIRST       = 1,
   parameter int MSB_FIRST     = 1
) (
   input  logic [BITS_PER_RAIL-1:0]   sym_i,
   input  logic [BITS_PER_RAIL-1:0]   sym_q,
   output logic [2*BITS_PER_RAIL-1:0] word
);

   logic [BITS_PER_RAIL-1:0] i_bin, q_bin;
   logic [BITS_PER_RAIL-1:0] i_ord, q_ord;

   always_comb begin
`ifdef P2S_GRAY_EN
      i_bin = BITS_PER_RAIL'(gray2bin(8'(sym_i)));
      q_bin = BITS_PER_RAIL'(gray2bin(8'(sym_q)));
`else
      i_bin = sym_i;
      q_bin = sym_q;
`endif
      i_ord = i_bin;
      q_ord = q_bin;
      if (MSB_FIRST == 0) begin
         for (int k = 0; k < BITS_PER_RAIL; k++) begin
            i_ord[k] = i_bin[BITS_PER_RAIL-1-k];
            q_ord[k] = q_bin[BITS_PER_RAIL-1-k];
         end
      end
      word = (Q_FIRST != 0) ? {q_ord, i_ord} : {i_ord, q_ord};
   end

endmodule

// File: rtl/qam_p2s_serializer.sv
// Slicer-output parallel-to-serial converter with one-deep holding register.
// Define P2S_GRAY_EN to Gray-decode each rail before serialisation.
module qam_p2s_serializer
   import qam_pkg::*;
#(
   parameter int BITS_PER_RAIL = 2,
   parameter int Q_FIRST       = 1,
   parameter int MSB_FIRST     = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sam_clk_en,
   input  logic                     sym_valid,
   output logic                     sym_ready,
   input  logic [BITS_PER_RAIL-1:0] sym_I,
   input  logic [BITS_PER_RAIL-1:0] sym_Q,
   output logic                     p_to_s,
   output logic                     bit_valid,
   output logic                     sym_start,
   output logic                     underrun
);

   localparam int N  = sym_len(BITS_PER_RAIL);
   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   p2s_state_t    state_q, state_d;
   logic [N-1:0]  hold_q, hold_d, sr_q, sr_d, word;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic          hold_full_q, hold_full_d;
   logic          p_to_s_q, p_to_s_d;
   logic          bit_valid_q, bit_valid_d;
   logic          sym_start_q, sym_start_d;
   logic          underrun_q, underrun_d;
   logic          boundary, consume, accept;

   p2s_word_build #(
      .BITS_PER_RAIL(BITS_PER_RAIL),
      .Q_FIRST      (Q_FIRST),
      .MSB_FIRST    (MSB_FIRST)
   ) u_build (
      .sym_i(sym_I),
      .sym_q(sym_Q),
      .word (word)
   );

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      p_to_s_d    = p_to_s_q;
      bit_valid_d = bit_valid_q;
      sym_start_d = sym_start_q;
      underrun_d  = 1'b0;

      boundary  = (state_q == IDLE) || (bit_cnt_q == '0);
      consume   = sam_clk_en & hold_full_q & boundary;
      sym_ready = ~hold_full_q | consume;
      accept    = sym_valid & sym_ready;

      // Consume and accept may coincide: old word shifts out, new one lands.
      hold_full_d = accept | (hold_full_q & ~consume);
      hold_d      = accept ? word : hold_q;

      if (sam_clk_en) begin
         unique case (1'b1)
            consume: begin
               state_d     = RUN;
               p_to_s_d    = hold_q[N-1];
               sr_d        = hold_q << 1;
               sym_start_d = 1'b1;
               bit_valid_d = 1'b1;
               bit_cnt_d   = ONE;
            end
            boundary & ~hold_full_q: begin
               state_d     = IDLE;
               p_to_s_d    = 1'b0;
               sym_start_d = 1'b0;
               bit_valid_d = 1'b0;
               underrun_d  = (state_q == RUN);
            end
            ~boundary: begin
               p_to_s_d    = sr_q[N-1];
               sr_d        = sr_q << 1;
               sym_start_d = 1'b0;
               bit_valid_d = 1'b1;
               bit_cnt_d   = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + ONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         hold_full_q <= 1'b0;
         p_to_s_q    <= 1'b0;
         bit_valid_q <= 1'b0;
         sym_start_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         hold_full_q <= hold_full_d;
         p_to_s_q    <= p_to_s_d;
         bit_valid_q <= bit_valid_d;
         sym_start_q <= sym_start_d;
         underrun_q  <= underrun_d;
      end
   end

   assign p_to_s    = p_to_s_q;
   assign bit_valid = bit_valid_q;
   assign sym_start = sym_start_q;
   assign underrun  = underrun_q;

endmodule

// File: doc/qam_p2s_serializer.md
Name: qam_p2s_serializer

Overview:
- Parametrised successor to the slicer-output parallel-to-serial converter in the QAM receive chain.
- Accepts one sliced symbol per handshake (I and Q rails, BITS_PER_RAIL bits each) into a one-deep holding register.
- Emits the symbol one bit per sam_clk_en strobe in a configurable rail and bit order.
- Flags a symbol start on the first bit of each symbol and flags underrun when no symbol is ready at a symbol boundary.

Parameters:
- BITS_PER_RAIL, 2: bits per I or Q rail; symbol length N = 2*BITS_PER_RAIL (range 1..8).
- Q_FIRST, 1: 1 = Q rail serialised before I; 0 = I rail before Q.
- MSB_FIRST, 1: 1 = each rail sent MSB to LSB; 0 = LSB to MSB.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sam_clk_en  in  1  bit strobe; one output bit per high cycle.
- sym_valid  in  1  sym_I and sym_Q are valid.
- sym_ready  out  1  holding register can accept a symbol this cycle.
- sym_I  in  BITS_PER_RAIL  sliced in-phase symbol.
- sym_Q  in  BITS_PER_RAIL  sliced quadrature symbol.
- p_to_s  out  1  serial bit, registered.
- bit_valid  out  1  p_to_s carries a symbol bit; updated only on strobe cycles.
- sym_start  out  1  p_to_s is bit 0 of a symbol; updated only on strobe cycles.
- underrun  out  1  one-clk pulse when a symbol boundary arrives with the holding register empty.

Behaviour:
- Reset (asynchronous, while reset = 0): p_to_s, bit_valid, sym_start, underrun, hold_full and bit_cnt all 0; state IDLE; sym_ready = 1 after release.
- Word build: W = {first rail, second rail}, with rails ordered per Q_FIRST and each rail bit-reversed when MSB_FIRST = 0. W[N-1] is transmitted first.
- Holding register and handshake:
  - sym_ready = ~hold_full | consume, where consume is the strobe cycle that loads the shift register.
  - Accept on sym_valid & sym_ready; hold_full is set next clk.
  - A simultaneous accept and consume is legal: the old word moves to the shift register and the new word enters the holding register in the same cycle, with no bubble.
- States:
  - IDLE: on a strobe with hold_full = 1, go to RUN and consume the first symbol. On a strobe with hold_full = 0, bit_valid <= 0, p_to_s <= 0, no underrun.
  - RUN, strobe with bit_cnt = 0 (symbol boundary):
    - if hold_full: p_to_s <= H[N-1]; SR <= H << 1; hold cleared unless reloaded; sym_start <= 1; bit_valid <= 1; bit_cnt <= 1.
    - else: underrun pulses for 1 clk; p_to_s <= 0; bit_valid <= 0; go to IDLE.
  - RUN, strobe with bit_cnt != 0: p_to_s <= SR[N-1]; SR <<= 1; sym_start <= 0; bit_valid <= 1; bit_cnt <= bit_cnt + 1, wrapping N-1 -> 0.
- Non-strobe cycles: p_to_s, bit_valid, sym_start, SR and bit_cnt hold their values; underrun <= 0.
- Latency: p_to_s is valid 1 clk after the consuming strobe.
- Throughput: 1 symbol per N strobes with no gaps as long as the holding register is refilled before each boundary.
- bit_cnt width: $clog2(N), minimum 1.
- sym_I and sym_Q are ignored when no accept occurs.
- Reset asserted mid-symbol discards the holding register and the partial symbol, with no underrun pulse.

Optional Feature:
- Macro: P2S_GRAY_EN.
- Defined: each rail is Gray-to-binary converted (b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]) before word build. The conversion is registered into the holding register, so accept-to-consume timing is unchanged.
- Undefined: rails pass unchanged.

Decomposition:
- Shared package qam_pkg: symbol length function sym_len(BITS_PER_RAIL), state enum p2s_state_t {IDLE, RUN}, and the gray2bin function, also used by the slicer.
- One natural sub-module: p2s_word_build, combinational. It takes sym_I, sym_Q and the parameters and produces W, including the Gray conversion when P2S_GRAY_EN is defined.

Test Plan:
- Defaults; I = 2'b10, Q = 2'b01 loaded; 4 strobes -> p_to_s sequence 0,1,1,0; sym_start high on the first bit only; bit_valid high on all four.
- Q_FIRST = 0, MSB_FIRST = 0, same symbol -> sequence 0,1,1,0 (I LSB-first = 0,1; Q = 1,0). BITS_PER_RAIL = 3 with I = 3'b110, Q = 3'b001 (defaults) -> 0,0,1,1,1,0.
- Back-to-back symbols, sym_valid held high with strobe every 3rd clk -> 12 contiguous bits for 3 symbols; sym_start at bits 0, 4, 8; no underrun.
- Stop sym_valid after 1 symbol -> at the 5th strobe underrun pulses for exactly 1 clk, bit_valid = 0, state returns to IDLE. A later load then resumes with sym_start = 1.
- Assert reset at bit 2 with the holding register full -> all outputs 0 immediately (asynchronous); sym_ready = 1 after release; the first strobe after release emits nothing.
- P2S_GRAY_EN defined, I = 2'b11 (Gray), Q = 2'b01 -> binary I = 10, Q = 01; sequence 0,1,1,0.
